// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, optional r0 hardwiring,
// writeback-to-read bypass and a sequenced clear of the whole array.
module regfile_scoreboard #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [ADDR_W-1:0] rA,
   input  logic [ADDR_W-1:0] rB,
   output logic [WIDTH-1:0]  aData,
   output logic [WIDTH-1:0]  bData,
   output logic              aBusy,
   output logic              bBusy,
   input  logic              wEnable,
   input  logic [ADDR_W-1:0] dR,
   input  logic [WIDTH-1:0]  wData,
   input  logic              rsvEnable,
   input  logic [ADDR_W-1:0] rsvR,
   input  logic              clrReq,
   output logic              clrBusy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              wr_ok, rsv_ok;

   always_comb begin
      wr_ok  = wEnable   && !(ZERO_REG && (dR   == '0));
      rsv_ok = rsvEnable && !(ZERO_REG && (rsvR == '0));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clrReq) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == CLEAR) begin
            regs_q[cnt_q] <= '0;
            busy_q[cnt_q] <= 1'b0;
         end else begin
            if (wr_ok) begin
               regs_q[dR] <= wData;
               busy_q[dR] <= 1'b0;
            end
            // Reserve is applied after writeback so a new producer keeps the register busy.
            if (rsv_ok) begin
               busy_q[rsvR] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      clrBusy = (state_q == CLEAR);

      if (state_q == CLEAR) begin
         aData = regs_q[rA];
         aBusy = 1'b1;
      end else if (ZERO_REG && (rA == '0)) begin
         aData = '0;
         aBusy = 1'b0;
      end else if (BYPASS && wr_ok && (dR == rA)) begin
         aData = wData;
         aBusy = 1'b0;
      end else begin
         aData = regs_q[rA];
         aBusy = busy_q[rA];
      end

      if (state_q == CLEAR) begin
         bData = regs_q[rB];
         bBusy = 1'b1;
      end else if (ZERO_REG && (rB == '0)) begin
         bData = '0;
         bBusy = 1'b0;
      end else if (BYPASS && wr_ok && (dR == rB)) begin
         bData = wData;
         bBusy = 1'b0;
      end else begin
         bData = regs_q[rB];
         bBusy = busy_q[rB];
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus
// randomized traffic compared against an array-level reference model.
module tb_regfile_scoreboard;

   localparam int W  = 32;
   localparam int AW = 5;
   localparam int D  = 32;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic [AW-1:0] rA, rB, dR, rsvR;
   logic [W-1:0]  aData, bData, wData;
   logic          aBusy, bBusy, wEnable, rsvEnable, clrReq, clrBusy;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] m_reg [D];
   bit           m_busy [D];
   bit           m_clr;
   int           m_cnt;

   regfile_scoreboard #(
      .WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .rA(rA), .rB(rB), .aData(aData), .bData(bData),
      .aBusy(aBusy), .bBusy(bBusy), .wEnable(wEnable), .dR(dR), .wData(wData),
      .rsvEnable(rsvEnable), .rsvR(rsvR), .clrReq(clrReq), .clrBusy(clrBusy)
   );

   always #5 CLK = ~CLK;

   // Reference behaviour at one rising edge, from the current inputs.
   function automatic void model_edge();
      if (!RSTn) begin
         for (int i = 0; i < D; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
         end
         m_clr = 1'b0;
         m_cnt = 0;
      end else if (m_clr) begin
         m_reg[m_cnt]  = '0;
         m_busy[m_cnt] = 1'b0;
         if (m_cnt == D - 1) begin
            m_clr = 1'b0;
            m_cnt = 0;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end else begin
         if (wEnable && dR != 0) begin
            m_reg[dR]  = wData;
            m_busy[dR] = 1'b0;
         end
         if (rsvEnable && rsvR != 0) m_busy[rsvR] = 1'b1;
         if (clrReq) begin
            m_clr = 1'b1;
            m_cnt = 0;
         end
      end
   endfunction

   function automatic void predict(input logic [AW-1:0] a, output logic [W-1:0] d, output logic b);
      if (m_clr) begin
         d = m_reg[a];
         b = 1'b1;
      end else if (a == 0) begin
         d = '0;
         b = 1'b0;
      end else if (wEnable && dR == a) begin
         d = wData;
         b = 1'b0;
      end else begin
         d = m_reg[a];
         b = m_busy[a];
      end
   endfunction

   task automatic idle_inputs();
      wEnable   = 1'b0;
      rsvEnable = 1'b0;
      clrReq    = 1'b0;
      dR        = '0;
      rsvR      = '0;
      wData     = '0;
   endtask

   task automatic tick();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      idle_inputs();
      rA = 5'd3;
      rB = 5'd17;
      tick();
      tick();
      RSTn = 1'b1;
      #1;
      checks++;
      if (aData !== '0 || bData !== '0) begin
         failures++;
         $display("FAIL reset_data: aData=%h bData=%h expected 0", aData, bData);
      end
      checks++;
      if (aBusy !== 1'b0 || bBusy !== 1'b0 || clrBusy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: aBusy=%b bBusy=%b clrBusy=%b expected 0", aBusy, bBusy, clrBusy);
      end
   endtask

   task automatic test_write_read();
      wEnable = 1'b1; dR = 5'd5; wData = 32'hDEADBEEF; rA = 5'd0;
      #1;
      tick();
      idle_inputs();
      rA = 5'd5;
      #1;
      checks++;
      if (aData !== 32'hDEADBEEF || aBusy !== 1'b0) begin
         failures++;
         $display("FAIL write_read: aData=%h aBusy=%b expected deadbeef/0", aData, aBusy);
      end
   endtask

   task automatic test_reserve_bypass();
      rsvEnable = 1'b1; rsvR = 5'd7; rB = 5'd0;
      #1;
      tick();
      idle_inputs();
      rB = 5'd7;
      #1;
      checks++;
      if (bBusy !== 1'b1) begin
         failures++;
         $display("FAIL reserve_busy: bBusy=%b expected 1", bBusy);
      end
      wEnable = 1'b1; dR = 5'd7; wData = 32'h1234;
      #1;
      checks++;
      if (bData !== 32'h1234 || bBusy !== 1'b0) begin
         failures++;
         $display("FAIL bypass: bData=%h bBusy=%b expected 1234/0", bData, bBusy);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (bData !== 32'h1234 || bBusy !== 1'b0) begin
         failures++;
         $display("FAIL after_writeback: bData=%h bBusy=%b expected 1234/0", bData, bBusy);
      end
   endtask

   task automatic test_zero_reg();
      wEnable = 1'b1; dR = 5'd0; wData = 32'hFFFFFFFF; rA = 5'd0;
      #1;
      checks++;
      if (aData !== '0) begin
         failures++;
         $display("FAIL zero_no_bypass: aData=%h expected 0", aData);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (aData !== '0) begin
         failures++;
         $display("FAIL zero_write: aData=%h expected 0", aData);
      end
      rsvEnable = 1'b1; rsvR = 5'd0;
      #1;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (aBusy !== 1'b0) begin
         failures++;
         $display("FAIL zero_reserve: aBusy=%b expected 0", aBusy);
      end
   endtask

   task automatic test_same_edge();
      wEnable = 1'b1; dR = 5'd9; wData = 32'h55;
      rsvEnable = 1'b1; rsvR = 5'd9;
      #1;
      tick();
      idle_inputs();
      rA = 5'd9;
      #1;
      checks++;
      if (aData !== 32'h55 || aBusy !== 1'b1) begin
         failures++;
         $display("FAIL same_edge: aData=%h aBusy=%b expected 55/1", aData, aBusy);
      end
   endtask

   task automatic test_clear();
      int n;
      logic [W-1:0] ed;
      logic         eb;
      for (int i = 1; i < D; i++) begin
         wEnable = 1'b1; dR = AW'(i); wData = $urandom;
         rsvEnable = ($urandom_range(0, 1) == 1); rsvR = AW'(i);
         #1;
         tick();
      end
      idle_inputs();
      clrReq = 1'b1;
      #1;
      tick();
      idle_inputs();
      n = 0;
      while (clrBusy === 1'b1 && n < 40) begin
         wEnable   = 1'b1; dR = AW'($urandom_range(1, D - 1)); wData = $urandom;
         rsvEnable = 1'b1; rsvR = AW'($urandom_range(1, D - 1));
         clrReq    = $urandom_range(0, 1) == 1;
         rA        = AW'($urandom_range(0, D - 1));
         rB        = dR;
         #1;
         predict(rA, ed, eb);
         checks++;
         if (aData !== ed || aBusy !== 1'b1 || bBusy !== 1'b1) begin
            failures++;
            $display("FAIL clear_reads: cyc=%0d aData=%h aBusy=%b bBusy=%b expected %h/1/1", n, aData, aBusy, bBusy, ed);
         end
         n++;
         tick();
      end
      idle_inputs();
      #1;
      checks++;
      if (n != D) begin
         failures++;
         $display("FAIL clear_length: clrBusy high %0d cycles expected %0d", n, D);
      end
      for (int i = 0; i < D; i++) begin
         rA = AW'(i);
         rB = AW'(D - 1 - i);
         #1;
         checks++;
         if (aData !== '0 || bData !== '0 || aBusy !== 1'b0 || bBusy !== 1'b0) begin
            failures++;
            $display("FAIL clear_result: addr=%0d aData=%h bData=%h aBusy=%b bBusy=%b expected 0", i, aData, bData, aBusy, bBusy);
         end
      end
   endtask

   task automatic test_reset_during_clear();
      for (int i = 1; i < D; i += 3) begin
         wEnable = 1'b1; dR = AW'(i); wData = $urandom | 32'h1;
         rsvEnable = 1'b1; rsvR = AW'(i);
         #1;
         tick();
      end
      idle_inputs();
      clrReq = 1'b1;
      #1;
      tick();
      idle_inputs();
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (clrBusy !== 1'b1) begin
         failures++;
         $display("FAIL abort_precondition: clrBusy=%b expected 1", clrBusy);
      end
      RSTn = 1'b0;
      tick();
      RSTn = 1'b1;
      #1;
      checks++;
      if (clrBusy !== 1'b0) begin
         failures++;
         $display("FAIL abort_clrbusy: clrBusy=%b expected 0", clrBusy);
      end
      for (int i = 0; i < D; i++) begin
         rA = AW'(i);
         rB = AW'(i);
         #1;
         checks++;
         if (aData !== '0 || bData !== '0 || aBusy !== 1'b0 || bBusy !== 1'b0) begin
            failures++;
            $display("FAIL abort_result: addr=%0d aData=%h bData=%h aBusy=%b bBusy=%b expected 0", i, aData, bData, aBusy, bBusy);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ead, ebd;
      logic         eab, ebb;
      for (int c = 0; c < 600; c++) begin
         RSTn      = ($urandom_range(0, 199) != 0);
         wEnable   = $urandom_range(0, 1) == 1;
         dR        = AW'($urandom_range(0, 7));
         wData     = $urandom;
         rsvEnable = $urandom_range(0, 2) == 0;
         rsvR      = AW'($urandom_range(0, 7));
         clrReq    = ($urandom_range(0, 59) == 0);
         rA        = ($urandom_range(0, 1) == 1) ? dR : AW'($urandom_range(0, 7));
         rB        = AW'($urandom_range(0, 7));
         #1;
         predict(rA, ead, eab);
         predict(rB, ebd, ebb);
         checks++;
         if (aData !== ead || aBusy !== eab || bData !== ebd || bBusy !== ebb || clrBusy !== m_clr) begin
            failures++;
            $display("FAIL random: cyc=%0d rA=%0d rB=%0d got a=%h/%b b=%h/%b clr=%b expected a=%h/%b b=%h/%b clr=%b",
                     c, rA, rB, aData, aBusy, bData, bBusy, clrBusy, ead, eab, ebd, ebb, m_clr);
         end
         tick();
      end
      RSTn = 1'b1;
      idle_inputs();
   endtask

   initial begin
      RSTn = 1'b0;
      rA = '0;
      rB = '0;
      idle_inputs();
      m_clr = 1'b0;
      m_cnt = 0;
      @(posedge CLK);
      #1;
      test_reset();
      test_write_read();
      test_reserve_bypass();
      test_zero_reg();
      test_same_edge();
      test_clear();
      test_reset_during_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
